// File: rtl/mc_pkg.sv
// mc_pkg: constants shared by the multi-cycle sequencer, mycpu_top and the bench.
//   mc_state_e        - 3-bit sequencer state encoding (IF..HALT; 6-7 illegal)
//   RESET_PC_DEFAULT  - architectural PC after reset
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } mc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencer for the LoongArch core.
// Owns pc, npc, ir, mdr and the retired-instruction counter, and walks each
// instruction through IF/ID/EX/MEM/WB with valid/ack handshakes to the
// instruction and data SRAM ports. Optional single-step mode parks in HALT
// after every retirement.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   inst_req/inst_addr/inst_ack/inst_rdata - instruction fetch handshake
//   ir                              - latched instruction for the decoder
//   dec_load/dec_store/dec_gr_we    - decoder qualifiers
//   dec_br_taken/br_target          - branch resolution, sampled in EX
//   data_req/data_we/data_ack/data_rdata - data access handshake
//   mdr                             - latched load data
//   rf_we                           - regfile write strobe (WB)
//   pc, retire, instret             - architectural PC, retire pulse, count
//   step_mode/step_go/halted        - single-step control
//   state                           - current state, for debug
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             inst_req,
    output logic [XLEN-1:0]  inst_addr,
    input  logic             inst_ack,
    input  logic [XLEN-1:0]  inst_rdata,
    output logic [XLEN-1:0]  ir,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_gr_we,
    input  logic             dec_br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic             data_req,
    output logic             data_we,
    input  logic             data_ack,
    input  logic [XLEN-1:0]  data_rdata,
    output logic [XLEN-1:0]  mdr,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    input  logic             step_mode,
    input  logic             step_go,
    output logic             halted,
    output logic [2:0]       state
);

    mc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  npc_q, npc_d;
    logic [XLEN-1:0]  ir_q, ir_d;
    logic [XLEN-1:0]  mdr_q, mdr_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IF;
            pc_q      <= XLEN'(RESET_PC);
            npc_q     <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        inst_req  = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_IF: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    ir_d    = inst_rdata;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                state_d = ST_EX;
            end
            ST_EX: begin
                npc_d   = dec_br_taken ? br_target : pc_q + XLEN'(4);
                state_d = (dec_load || dec_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                data_req = 1'b1;
                data_we  = dec_store;
                if (data_ack) begin
                    if (dec_load) begin
                        mdr_d = data_rdata;
                    end
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we     = dec_gr_we & ~dec_store;
                retire    = 1'b1;
                pc_d      = npc_q;
                instret_d = instret_q + CNT_W'(1);
                state_d   = step_mode ? ST_HALT : ST_IF;
            end
            ST_HALT: begin
                halted = 1'b1;
                // Either release condition (or both together) gives one hop to IF.
                if (step_go || !step_mode) begin
                    state_d = ST_IF;
                end
            end
            default: begin
                state_d = ST_IF;
            end
        endcase

        // The state register may still hold a mid-access state during the
        // reset cycle; suppress every strobe so nothing leaks out.
        if (reset) begin
            inst_req = 1'b0;
            data_req = 1'b0;
            data_we  = 1'b0;
            rf_we    = 1'b0;
            retire   = 1'b0;
            halted   = 1'b0;
        end
    end

    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the LoongArch core: owns the PC, instruction register, memory data register and retired-instruction counter. It steps each instruction through IF/ID/EX/MEM/WB and drives valid/ack handshakes to the instruction and data SRAM ports, so memories may take any number of cycles. The existing decoder, regfile and alu sit around it. An optional single-step mode halts after every retirement.

## Interface
Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h1c000000, PC value after reset
- CNT_W, 32, instret counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  out  1  instruction fetch request
- inst_addr  out  XLEN  fetch address (= pc)
- inst_ack  in  1  fetch data valid this cycle
- inst_rdata  in  XLEN  fetched word
- ir  out  XLEN  latched instruction, fed to the decoder
- dec_load  in  1  decoded ld.w
- dec_store  in  1  decoded st.w
- dec_gr_we  in  1  decoded regfile write
- dec_br_taken  in  1  branch/jump taken, valid in EX
- br_target  in  XLEN  branch target, valid in EX
- data_req  out  1  data access request
- data_we  out  1  store qualifier for data_req
- data_ack  in  1  data access complete
- data_rdata  in  XLEN  load data
- mdr  out  XLEN  latched load data
- rf_we  out  1  regfile write strobe
- pc  out  XLEN  current PC
- retire  out  1  one-cycle pulse per retired instruction
- instret  out  CNT_W  retired-instruction count
- step_mode  in  1  halt after each retirement
- step_go  in  1  release from HALT
- halted  out  1  in HALT
- state  out  3  current state, for debug

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6-7 are illegal and go to IF next cycle.
- IF: inst_req=1, inst_addr=pc, held stable until ack. On inst_ack: ir<=inst_rdata, go to ID.
- ID: one cycle for regfile read. Go to EX.
- EX: npc<=dec_br_taken ? br_target : pc+4 (mod 2^XLEN). Go to MEM if dec_load|dec_store, else WB.
- MEM: data_req=1, data_we=dec_store, both held until data_ack. On ack: mdr<=data_rdata if dec_load. Go to WB.
- WB: rf_we=dec_gr_we & ~dec_store; pc<=npc; retire=1; instret<=instret+1, wrapping at 2^CNT_W. Go to HALT if step_mode, else IF.
- HALT: halted=1, no requests. Go to IF on step_go or when step_mode falls.
- Acks outside the matching request state are ignored.
- ir, mdr and npc hold their value outside their capture states.

## Timing
- Reset: state=IF, pc=RESET_PC, ir=0, mdr=0, npc=0, instret=0.
- While reset is high: inst_req, data_req, data_we, rf_we, retire and halted are all 0.
- First fetch request is in the first cycle after reset deasserts.
- Zero-wait ack (ack in the first request cycle) is legal. Minimum latency is 4 cycles for ALU/branch instructions and 5 for load/store; each wait cycle adds one.
- All request and write outputs are combinational decodes of the state register (plus dec_*). Every register updates on the posedge.
- Reset mid-access abandons the transaction. No write strobe is issued in the reset cycle.
- step_go and step_mode falling in the same cycle: a single transition to IF.
- step_go outside HALT is ignored.

## Structure
- Shared package mc_pkg holds the state encoding constants (IF..HALT, 3 bits) and RESET_PC_DEFAULT, both reused by mycpu_top and the bench.
- No sub-module needed: the FSM, PC/npc, ir/mdr and the counter are implemented inline. mycpu_top instantiates mc_ctrl next to the decoders, regfile and alu.

## Test plan
- Reset then add.w with ack on the first cycle: inst_addr=0x1c000000, states IF,ID,EX,WB. retire pulses in cycle 4, pc becomes 0x1c000004, instret=1.
- Fetch with inst_ack delayed 3 cycles: inst_req and inst_addr stay stable for 4 cycles, ir changes only on the ack cycle.
- Taken beq (br_target=0x1c000100) in EX: pc=0x1c000100 after WB. Not-taken: pc=pc+4.
- ld.w with data_ack after 2 waits and data_rdata=0xdeadbeef: mdr=0xdeadbeef, rf_we=1 in WB. st.w: data_we=1 in MEM, rf_we=0.
- Step mode with 3 instructions: halted after each retire, no inst_req until step_go. Drop step_mode while halted: resumes at IF.
- Preload instret to all-ones (CNT_W=4): wraps to 0 on the next retire. Reset asserted in MEM: no rf_we, next state IF at RESET_PC.
